// File: rtl/adder_tree.sv
// adder_tree: pipelined balanced binary adder tree.
// Sums N unsigned 128-bit operands modulo 2^128. Level k adds the adjacent
// partial-sum pairs (2j, 2j+1) of level k-1, giving log2(N) adder levels.
// Optional feature macro: ADDER_TREE_PIPE_EN
//   defined   -> a register stage follows every tree level (latency log2(N))
//   undefined -> combinational tree, only sum/out_valid are registered (latency 1)
// in_valid rides along with the data. Groups with in_valid=0 still flow
// through the pipeline, but sum only reloads when a valid result arrives.

module adder_tree #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [128*N-1:0] in,
  output logic [127:0]     sum,
  output logic             out_valid
);

  localparam int LEVELS = $clog2(N);

  logic [127:0] sum_d;
  logic [127:0] sum_q;
  logic         out_valid_d;
  logic         out_valid_q;

  // Level k holds N>>k partial sums; level 0 is the raw operand vector.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int W = N >> k;

    logic [W-1:0][127:0] node;
    logic                node_valid;

    if (k == 0) begin : g_leaf
      assign node       = in;
      assign node_valid = in_valid;
    end else begin : g_add
      logic [W-1:0][127:0] node_d;
      logic                node_valid_d;

      // Add adjacent pairs of the previous level; carries past bit 127 drop.
      always_comb begin
        node_d       = '0;
        node_valid_d = g_lvl[k-1].node_valid;
        for (int j = 0; j < W; j++) begin
          node_d[j] = g_lvl[k-1].node[2*j] + g_lvl[k-1].node[2*j+1];
        end
      end

`ifdef ADDER_TREE_PIPE_EN
      // The last level feeds the output register directly, so it gets no
      // stage of its own; every other level is registered here.
      if (k < LEVELS) begin : g_pipe
        logic [W-1:0][127:0] node_q;
        logic                node_valid_q;

        // Pipeline register behind this level, cleared by synchronous reset.
        always_ff @(posedge clk) begin
          if (rst) begin
            node_q       <= '0;
            node_valid_q <= 1'b0;
          end else begin
            node_q       <= node_d;
            node_valid_q <= node_valid_d;
          end
        end

        assign node       = node_q;
        assign node_valid = node_valid_q;
      end else begin : g_comb
        assign node       = node_d;
        assign node_valid = node_valid_d;
      end
`else
      assign node       = node_d;
      assign node_valid = node_valid_d;
`endif
    end
  end

  // Output stage: capture the root only when it carries a valid group.
  always_comb begin
    out_valid_d = g_lvl[LEVELS].node_valid;
    sum_d       = out_valid_d ? g_lvl[LEVELS].node[0] : sum_q;
  end

  // Output register holding sum and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree.sv
// tb_adder_tree: self-checking bench for adder_tree.
// Five instances (N = 8, 16, 32, 64, 128) share one wide operand bus; each sees
// its lowest N operands. A delay-line model predicts every output each cycle,
// and directed vectors pin hand-computed sums on the N=8 and N=128 instances.
// Build with or without ADDER_TREE_PIPE_EN; expected latency follows the macro.

module tb_adder_tree;

  localparam int NUM_DUT = 5;
  localparam int MAX_N   = 128;
  localparam int MAX_L   = 7;
  localparam int BUS_W   = 128 * MAX_N;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [BUS_W-1:0] in_all;
  logic [127:0]     sum_out       [NUM_DUT];
  logic             out_valid_out [NUM_DUT];

  int assert_count = 0;
  int fail_count   = 0;

  logic             model_ready = 1'b0;
  logic             hist_valid [MAX_L];
  logic [BUS_W-1:0] hist_data  [MAX_L];
  logic             exp_valid  [NUM_DUT];
  logic [127:0]     exp_sum    [NUM_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
    localparam int NN = 8 << g;
    adder_tree #(.N(NN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in_all[128*NN-1:0]),
      .sum       (sum_out[g]),
      .out_valid (out_valid_out[g])
    );
  end

  // Cycles from sampling a group to its result appearing on the outputs.
  function automatic int lat_of(input int n);
`ifdef ADDER_TREE_PIPE_EN
    return $clog2(n);
`else
    return (n > 0) ? 1 : 1;
`endif
  endfunction

  // Reference: full-precision sum of the first n operands, truncated to 128 bits.
  function automatic logic [127:0] model_sum(input logic [BUS_W-1:0] data, input int n);
    logic [255:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      acc = acc + {128'd0, data[128*i +: 128]};
    end
    return acc[127:0];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive the valid flag and fill every operand slot with the same value.
  task automatic applyStimulus(input logic valid, input logic [127:0] fill_val);
    in_valid = valid;
    for (int i = 0; i < MAX_N; i++) begin
      in_all[128*i +: 128] = fill_val;
    end
  endtask

  // Model: remember each sampled group; reset forgets everything in flight.
  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < MAX_L; d++) begin
        hist_valid[d] = 1'b0;
        hist_data[d]  = '0;
      end
      for (int g = 0; g < NUM_DUT; g++) begin
        exp_valid[g] = 1'b0;
        exp_sum[g]   = '0;
      end
      model_ready = 1'b1;
    end else begin
      for (int d = MAX_L - 1; d > 0; d--) begin
        hist_valid[d] = hist_valid[d-1];
        hist_data[d]  = hist_data[d-1];
      end
      hist_valid[0] = in_valid;
      hist_data[0]  = in_all;
      for (int g = 0; g < NUM_DUT; g++) begin
        if (hist_valid[lat_of(8 << g) - 1]) begin
          exp_valid[g] = 1'b1;
          exp_sum[g]   = model_sum(hist_data[lat_of(8 << g) - 1], 8 << g);
        end else begin
          exp_valid[g] = 1'b0;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      for (int g = 0; g < NUM_DUT; g++) begin
        checkOutput($sformatf("model_valid_n%0d", 8 << g),
                    128'(out_valid_out[g]), 128'(exp_valid[g]));
        checkOutput($sformatf("model_sum_n%0d", 8 << g), sum_out[g], exp_sum[g]);
      end
    end
  end

  // Directed and random stimulus.
  initial begin
    int           lat8;
    int           lat128;
    int           pulses;
    int           issued;
    int           cycles;
    int           r;
    logic [127:0] seq_exp [3];

    lat8       = lat_of(8);
    lat128     = lat_of(128);
    seq_exp[0] = 128'd36;
    seq_exp[1] = 128'd100;
    seq_exp[2] = 128'd164;

    rst = 1'b1;
    applyStimulus(1'b0, 128'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_sum", sum_out[0], 128'd0);
    checkOutput("reset_valid", 128'(out_valid_out[0]), 128'd0);
    rst = 1'b0;

    // All operands 1, a single valid cycle.
    applyStimulus(1'b1, 128'd1);
    for (int t = 1; t <= lat128 + 1; t++) begin
      @(negedge clk);
      applyStimulus(1'b0, 128'd0);
      if (t == lat8) begin
        checkOutput("ones_n8_valid", 128'(out_valid_out[0]), 128'd1);
        checkOutput("ones_n8_sum", sum_out[0], 128'd8);
      end
      if (t == lat8 + 1) begin
        checkOutput("ones_n8_pulse_end", 128'(out_valid_out[0]), 128'd0);
        checkOutput("ones_n8_sum_hold", sum_out[0], 128'd8);
      end
      if (t == lat128) begin
        checkOutput("ones_n128_sum", sum_out[4], 128'd128);
      end
    end

    // All operands at maximum: the sum wraps around.
    applyStimulus(1'b1, {128{1'b1}});
    for (int t = 1; t <= lat128; t++) begin
      @(negedge clk);
      applyStimulus(1'b0, 128'd0);
      if (t == lat8) begin
        checkOutput("max_n8_sum", sum_out[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF8);
      end
      if (t == lat128) begin
        checkOutput("max_n128_sum", sum_out[4], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF80);
      end
    end
    repeat (2) @(negedge clk);

    // Three back-to-back groups: operand i = i+1 plus 0, 8, 16.
    for (int t = 0; t < lat8 + 3; t++) begin
      if (t < 3) begin
        in_all = '0;
        for (int i = 0; i < 8; i++) begin
          in_all[128*i +: 128] = 128'(i + 1 + 8 * t);
        end
        in_valid = 1'b1;
      end else begin
        applyStimulus(1'b0, 128'd0);
      end
      @(negedge clk);
      r = t + 1 - lat8;
      if (r >= 0 && r < 3) begin
        checkOutput($sformatf("seq_valid_%0d", r), 128'(out_valid_out[0]), 128'd1);
        checkOutput($sformatf("seq_sum_%0d", r), sum_out[0], seq_exp[r]);
      end
    end
    checkOutput("seq_after_valid", 128'(out_valid_out[0]), 128'd0);
    checkOutput("seq_after_sum", sum_out[0], 128'd164);

    // Valid group followed one cycle later by reset; then a group right after reset.
    applyStimulus(1'b1, 128'd1);
    @(negedge clk);
    pulses = out_valid_out[0] ? 1 : 0;
    rst = 1'b1;
    applyStimulus(1'b0, 128'd0);
    @(negedge clk);
    checkOutput("flush_reset_sum", sum_out[0], 128'd0);
    checkOutput("flush_reset_valid", 128'(out_valid_out[0]), 128'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 128'd3);
    @(negedge clk);
    applyStimulus(1'b0, 128'd0);
    for (int c = 1; c < lat8; c++) begin
      if (out_valid_out[0]) pulses++;
      @(negedge clk);
    end
    checkOutput("flush_pulses", 128'(pulses), (lat8 == 1) ? 128'd1 : 128'd0);
    checkOutput("post_reset_valid", 128'(out_valid_out[0]), 128'd1);
    checkOutput("post_reset_sum", sum_out[0], 128'd24);

    // Random groups with occasional idle cycles carrying random data.
    issued = 0;
    cycles = 0;
    while (issued < 10 && cycles < 200) begin
      for (int w = 0; w < BUS_W / 32; w++) begin
        in_all[32*w +: 32] = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < MAX_N; i += 3) begin
          in_all[128*i +: 128] = {128{1'b1}};
        end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) issued++;
      @(negedge clk);
      cycles++;
    end
    if (issued < 10) begin
      checkOutput("random_issue_budget", 128'(issued), 128'd10);
    end

    applyStimulus(1'b0, 128'd0);
    repeat (MAX_L + 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/adder_tree.md
ADDER_TREE -- requirements
Module: adder_tree

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of 128-bit operands; legal values are powers of two from 2 to 128.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: qualifies in for the current cycle.
REQ-005 The block SHALL have port in, input, 128*N bits: operand i occupies bits [128*i+127 : 128*i], unsigned.
REQ-006 The block SHALL have port sum, output, 128 bits: registered sum of one operand group.
REQ-007 The block SHALL have port out_valid, output, 1 bit: sum holds a result this cycle.

Function
REQ-008 sum SHALL equal the sum of all N operands modulo 2^128; carries out of bit 127 at any level are discarded.
REQ-009 Addition SHALL be structured as a balanced binary tree of log2(N) levels; level k pairs adjacent partial sums (2j, 2j+1).
REQ-010 The block SHALL be fully pipelined: one new operand group per cycle, no backpressure, no stall input.
REQ-011 in_valid SHALL travel alongside its data; out_valid SHALL assert exactly when the result of a valid group appears at sum.
REQ-012 Latency from sampling in (with in_valid=1) to out_valid=1 SHALL be L cycles, fixed per REQ-018/REQ-019.
REQ-013 Groups with in_valid=0 SHALL still propagate as data; out_valid=0 for them, and sum is don't-care but deterministic.
REQ-014 sum SHALL update only on cycles where out_valid is driven to 1; otherwise it holds its last value.
REQ-015 Back-to-back valid groups SHALL produce back-to-back results in input order, with no gaps or reordering.

Reset
REQ-016 While rst=1 at a clock edge, all pipeline registers, valid bits and sum SHALL clear to 0, and out_valid SHALL be 0 the following cycle.
REQ-017 Assertion of rst mid-operation SHALL discard all in-flight groups; no result for them appears after reset deasserts; a group sampled on the first cycle after deassertion SHALL complete normally after L cycles.

Configuration
REQ-018 With macro ADDER_TREE_PIPE_EN defined, a register stage SHALL follow every tree level, giving L = log2(N) (3 for N=8).
REQ-019 Without ADDER_TREE_PIPE_EN, the tree SHALL be combinational with only the output register stage (sum, out_valid), giving L = 1; function is otherwise identical.

Verification
REQ-020 Bench SHALL cover: N=8, all operands 1, in_valid=1 for one cycle -> after L cycles sum=8 and out_valid=1 for exactly one cycle.
REQ-021 Bench SHALL cover: N=8, all operands 2^128-1 -> sum=FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF8 (wrap-around).
REQ-022 Bench SHALL cover: N=8, operand i = i+1 for three consecutive valid cycles, adding 0/8/16 per operand -> sums 36, 100, 164 on three consecutive cycles.
REQ-023 Bench SHALL cover: valid group issued, rst=1 one cycle later -> out_valid never asserts for that group, sum=0 after reset.
REQ-024 Bench SHALL cover: 10 random groups with N in {8,16,32,64,128} -> each sum equals a 256-bit reference sum truncated to bits [127:0], under both macro settings.
